// File: rtl/pulse_pkg.sv
// Shared state encoding, ADC range and event field widths for the pulse peak detector.
package pulse_pkg;

  localparam int ADC_W     = 14;
  localparam int ADC_MAX   = 8191;
  localparam int ADC_MIN   = -8192;
  localparam int TS_W_DEF  = 32;
  localparam int WID_W_DEF = 16;
  localparam int DROP_W    = 16;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_TRACK   = 2'd1,
    S_HOLDOFF = 2'd2
  } state_t;

  // Holdoff counter must hold the value HOLDOFF itself; keep at least one bit.
  function automatic int hold_cnt_w(input int holdoff);
    return (holdoff > 0) ? $clog2(holdoff + 1) : 1;
  endfunction

endpackage

// File: rtl/pulse_evt_reg.sv
// One-deep valid/ready event register: loads 1 clk after evt, frees on valid&ready.
// An event arriving while the register is full and not being drained is dropped and counted.
module pulse_evt_reg
  import pulse_pkg::*;
#(
  parameter int W     = ADC_W,
  parameter int TS_W  = TS_W_DEF,
  parameter int WID_W = WID_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                evt,
  input  logic signed [W-1:0] evt_height,
  input  logic [TS_W-1:0]     evt_time,
  input  logic [WID_W-1:0]    evt_width,
  input  logic                peak_ready,
  output logic                peak_valid,
  output logic signed [W-1:0] peak_height,
  output logic [TS_W-1:0]     peak_time,
  output logic [WID_W-1:0]    peak_width,
  output logic [DROP_W-1:0]   drop_count
);

  logic load;
  logic drop;

  assign load = evt && (!peak_valid || peak_ready);
  assign drop = evt && peak_valid && !peak_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      peak_valid  <= 1'b0;
      peak_height <= '0;
      peak_time   <= '0;
      peak_width  <= '0;
      drop_count  <= '0;
    end else begin
      if (load) begin
        peak_valid  <= 1'b1;
        peak_height <= evt_height;
        peak_time   <= evt_time;
        peak_width  <= evt_width;
      end else if (peak_ready) begin
        peak_valid  <= 1'b0;
      end
      if (drop && (drop_count != {DROP_W{1'b1}})) begin
        drop_count <= drop_count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pulse_peak_detect.sv
// Threshold-crossing pulse detector reporting peak height, peak index and width per pulse.
// Event is visible 1 clk after the terminating sample; a full, stalled output drops and counts it.
module pulse_peak_detect
  import pulse_pkg::*;
#(
  parameter int W         = ADC_W,
  parameter int TS_W      = TS_W_DEF,
  parameter int WID_W     = WID_W_DEF,
  parameter int MIN_WIDTH = 2,
  parameter int HOLDOFF   = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic signed [W-1:0] in_data,
  input  logic signed [W-1:0] threshold,
  input  logic                enable,
  output logic                peak_valid,
  input  logic                peak_ready,
  output logic signed [W-1:0] peak_height,
  output logic [TS_W-1:0]     peak_time,
  output logic [WID_W-1:0]    peak_width,
  output logic                busy,
  output logic [DROP_W-1:0]   drop_count
);

  localparam int HC_W = hold_cnt_w(HOLDOFF);

  state_t                state;
  logic [TS_W-1:0]       ts;
  logic [TS_W-1:0]       pk_ts;
  logic signed [W-1:0]   pk;
  logic [WID_W-1:0]      wid;
  logic [HC_W-1:0]       hcnt;
  logic                  above;
  logic                  evt;

  assign above = in_data > threshold;
  assign busy  = (state != S_IDLE);

  // Pulse end while armed: short pulses are runts and produce no event.
  assign evt = in_valid && enable && (state == S_TRACK) && !above &&
               (wid >= WID_W'(MIN_WIDTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      ts    <= '0;
      pk    <= '0;
      pk_ts <= '0;
      wid   <= '0;
      hcnt  <= '0;
    end else if (in_valid) begin
      ts <= ts + 1'b1;
      case (state)
        S_IDLE: begin
          if (enable && above) begin
            state <= S_TRACK;
            pk    <= in_data;
            pk_ts <= ts;
            wid   <= WID_W'(1);
          end
        end
        S_TRACK: begin
          if (!enable) begin
            state <= S_IDLE;
          end else if (above) begin
            if (wid != {WID_W{1'b1}}) wid <= wid + 1'b1;
            if (in_data > pk) begin
              pk    <= in_data;
              pk_ts <= ts;
            end
          end else if (HOLDOFF == 0) begin
            state <= S_IDLE;
          end else begin
            hcnt  <= HC_W'(HOLDOFF);
            state <= S_HOLDOFF;
          end
        end
        S_HOLDOFF: begin
          if (!enable) begin
            hcnt  <= '0;
            state <= S_IDLE;
          end else begin
            hcnt <= hcnt - 1'b1;
            if (hcnt == HC_W'(1)) state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  pulse_evt_reg #(
    .W     (W),
    .TS_W  (TS_W),
    .WID_W (WID_W)
  ) u_evt_reg (
    .clk         (clk),
    .rst         (rst),
    .evt         (evt),
    .evt_height  (pk),
    .evt_time    (pk_ts),
    .evt_width   (wid),
    .peak_ready  (peak_ready),
    .peak_valid  (peak_valid),
    .peak_height (peak_height),
    .peak_time   (peak_time),
    .peak_width  (peak_width),
    .drop_count  (drop_count)
  );

endmodule

// File: doc/pulse_peak_detect.md
Name: pulse_peak_detect

Overview:
- Downstream consumer of the genPulse simulated-ADC stream: takes signed 14-bit samples and detects pulses by threshold crossing.
- Per pulse, captures peak height, sample index of the peak and width (samples above threshold).
- Emits one event per pulse through a 1-deep valid/ready output register; counts events lost to backpressure.
- Feeds the histogram/readout stage.

Parameters:
- W, 14, sample width (signed, matches genPulse Y).
- TS_W, 32, sample-index counter width.
- WID_W, 16, pulse-width counter width.
- MIN_WIDTH, 2, minimum samples above threshold for a valid pulse; shorter pulses are runts and are discarded.
- HOLDOFF, 8, valid samples ignored after a pulse ends before re-arming (0 = re-arm immediately).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  sample strobe; state advances only when 1.
- in_data  in  W  signed sample.
- threshold  in  W  signed trigger level; sampled every valid cycle.
- enable  in  1  arm detector; 0 aborts any pulse in progress.
- peak_valid  out  1  event register holds an event.
- peak_ready  in  1  consumer accepts the event.
- peak_height  out  W  signed maximum sample of the pulse.
- peak_time  out  TS_W  sample index of the first occurrence of the maximum.
- peak_width  out  WID_W  samples strictly above threshold, saturating.
- busy  out  1  state is TRACK or HOLDOFF.
- drop_count  out  16  events lost because the output register was full; saturates at 0xFFFF.

Behaviour:
Reset:
- rst=1 asynchronously forces state IDLE.
- ts, peak_valid, peak_height, peak_time, peak_width, drop_count and the holdoff counter all go to 0.

Sample index and clocking:
- ts increments by 1 on every in_valid=1 cycle and wraps modulo 2^TS_W.
- The current sample's index is the ts value before the increment.
- in_valid=0: every register holds, except the output handshake.

Comparisons:
- All comparisons are signed.
- "above" means in_data > threshold (strict).

States:
- IDLE: on in_valid & enable & above → TRACK.
  - Load pk=in_data, pk_ts=ts, wid=1.
- TRACK, on each in_valid cycle:
  - If enable=0 → IDLE. Pulse discarded, no event, no holdoff.
  - Else if above: wid=wid+1, saturating at 2^WID_W-1. If in_data > pk (strict), pk=in_data and pk_ts=ts. Ties keep the earlier time.
  - Else (pulse end): if wid ≥ MIN_WIDTH, issue event (pk, pk_ts, wid); otherwise discard as a runt. Then, if HOLDOFF=0 → IDLE; else load hcnt=HOLDOFF → HOLDOFF.
- HOLDOFF: on each in_valid cycle, hcnt=hcnt-1. When hcnt reaches 0 → IDLE, so exactly HOLDOFF samples are ignored. Samples above threshold are ignored. enable=0 → IDLE immediately.

Event issue:
- If peak_valid=0, or peak_valid & peak_ready in the same cycle, load the register and set peak_valid=1 on the next edge. Latency is 1 clk after the terminating sample.
- Otherwise the event is dropped and drop_count increments, saturating.
- peak_valid & peak_ready with no new event → peak_valid=0 next cycle.
- Outputs are stable while peak_valid=1 and peak_ready=0.

Other boundaries:
- threshold changes mid-pulse apply from the next valid sample.
- Width saturation does not affect peak tracking.
- ts wrap mid-pulse is allowed; peak_time reports the raw wrapped index.

Decomposition:
- Package pulse_pkg:
  - state enum {IDLE, TRACK, HOLDOFF}, 2 bits.
  - localparams ADC_W=14, ADC_MAX=8191, ADC_MIN=-8192.
  - Event field widths.
- Sub-module pulse_evt_reg: 1-deep valid/ready holding register with drop detection and the saturating drop counter.
- FSM and tracking logic live in the top.

Test Plan:
1. Basic pulse: threshold=100, MIN_WIDTH=2, HOLDOFF=0, peak_ready=1. in_valid=1 on consecutive clocks from reset with samples 0,150,400,8191,300,50. Expect, one clk after sample 50: peak_valid=1, height=8191, time=3, width=4, drop_count=0.
2. Runt and tie: single 200 followed by 0 → no event. Then 150,500,500,20 → height=500, time = index of the first 500, width=3.
3. Backpressure: peak_ready=0, two valid pulses separated by HOLDOFF+2 samples. Expect the first event held unchanged and drop_count=1. Raise peak_ready → exactly one handshake, peak_valid=0 next cycle.
4. Holdoff: HOLDOFF=8, pulse ends, then a crossing 5 samples later → ignored, busy=1. A crossing 10 samples after the end → new pulse detected.
5. Negative domain: threshold=-50, samples -8192,-40,-10,-30,-8192 → height=-10, width=3. Confirms signed compare.
6. Abort/reset: drop enable mid-TRACK → no event, state IDLE. Assert rst asynchronously (off-edge) mid-pulse with peak_valid=1 → all outputs 0 immediately. After release, ts restarts at 0.
